// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
// Polyphonic voice allocator. Takes note-on / note-off events and binds every
// sounding note to one of NUM_VOICES voices, then presents a per-voice NCO
// divider. An idle voice presents divider 0. That value is below the NCO
// minimum, so the channel manager treats the channel as disabled.
//
// Each accepted event walks the voices one per cycle (SCAN). During the walk it
// records the first voice already holding the key and the lowest free voice.
// A single COMMIT cycle then applies one action. A voice is never stolen.
//
// Ports
//   sys_clk       pipeline clock
//   sys_rst       asynchronous active-high reset
//   evt_valid     event present
//   evt_ready     allocator idle and able to accept an event
//   evt_on        1 = note-on, 0 = note-off
//   evt_note      key number
//   evt_div       NCO divider for note-on (ignored for note-off)
//   panic         all-notes-off, sampled on every edge
//   voice_div     flattened dividers, voice v at [v*D_W +: D_W]
//   voice_active  voice ownership flags
//   alloc_fail    one-cycle pulse when a note-on is dropped
// ---------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int D_W        = 16,
    parameter int NOTE_W     = 7,
    parameter int MIN_DIV    = 4
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      evt_valid,
    output logic                      evt_ready,
    input  logic                      evt_on,
    input  logic [NOTE_W-1:0]         evt_note,
    input  logic [D_W-1:0]            evt_div,
    input  logic                      panic,
    output logic [NUM_VOICES*D_W-1:0] voice_div,
    output logic [NUM_VOICES-1:0]     voice_active,
    output logic                      alloc_fail
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_ready;
    logic                  r_fail;

    // Event latched at accept; the live inputs are ignored until the next accept.
    logic                  r_on;
    logic [NOTE_W-1:0]     r_note;
    logic [D_W-1:0]        r_div;

    logic                  r_match_hit;
    logic [IDX_W-1:0]      r_match_idx;
    logic                  r_free_hit;
    logic [IDX_W-1:0]      r_free_idx;

    logic [NOTE_W-1:0]     r_voice_note [NUM_VOICES];
    logic [D_W-1:0]        r_voice_div  [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_voice_active;

    logic                  w_scan_active;
    logic [NOTE_W-1:0]     w_scan_note;

    assign w_scan_active = r_voice_active[r_idx];
    assign w_scan_note   = r_voice_note[r_idx];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_ready        <= 1'b1;
            r_fail         <= 1'b0;
            r_on           <= 1'b0;
            r_note         <= '0;
            r_div          <= '0;
            r_match_hit    <= 1'b0;
            r_match_idx    <= '0;
            r_free_hit     <= 1'b0;
            r_free_idx     <= '0;
            r_voice_active <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_voice_note[v] <= '0;
                r_voice_div[v]  <= '0;
            end
        end else if (panic) begin
            // Panic wins over everything, including a COMMIT on this edge.
            // The in-flight event is discarded silently.
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_ready        <= 1'b1;
            r_fail         <= 1'b0;
            r_voice_active <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_voice_div[v] <= '0;
            end
        end else begin
            r_fail <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (evt_valid && r_ready) begin
                        r_on        <= evt_on;
                        r_note      <= evt_note;
                        r_div       <= evt_div;
                        r_match_hit <= 1'b0;
                        r_free_hit  <= 1'b0;
                        r_idx       <= '0;
                        r_ready     <= 1'b0;
                        r_state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_scan_active && (w_scan_note == r_note) && !r_match_hit) begin
                        r_match_hit <= 1'b1;
                        r_match_idx <= r_idx;
                    end
                    // The first free voice seen is the lowest-index free voice.
                    if (!w_scan_active && !r_free_hit) begin
                        r_free_hit <= 1'b1;
                        r_free_idx <= r_idx;
                    end
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(NUM_VOICES - 1)) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (r_on) begin
                        if (r_div < D_W'(MIN_DIV)) begin
                            r_fail <= 1'b1;
                        end else if (r_match_hit) begin
                            // Retrigger keeps the key in a single voice.
                            r_voice_div[r_match_idx] <= r_div;
                        end else if (r_free_hit) begin
                            r_voice_note[r_free_idx]   <= r_note;
                            r_voice_div[r_free_idx]    <= r_div;
                            r_voice_active[r_free_idx] <= 1'b1;
                        end else begin
                            r_fail <= 1'b1;
                        end
                    end else if (r_match_hit) begin
                        r_voice_active[r_match_idx] <= 1'b0;
                        r_voice_div[r_match_idx]    <= '0;
                    end
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Idle voices present divider 0.
    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice_out
            assign voice_div[gi*D_W +: D_W] = r_voice_active[gi] ? r_voice_div[gi] : '0;
        end
    endgenerate

    assign voice_active = r_voice_active;
    assign evt_ready    = r_ready;
    assign alloc_fail   = r_fail;

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator between the command/SPI front end and the NCO channel manager. It accepts note-on/note-off events, binds each sounding note to one of NUM_VOICES voices, and drives per-voice NCO dividers. A voice stays owned by its note until a matching note-off, a panic, or reset frees it. An idle voice outputs divider 0, which is below the NCO minimum of 4, so the channel manager treats that channel as disabled.

## Interface
- NUM_VOICES, 4, number of voices; power of two, ≥2
- D_W, 16, divider width
- NOTE_W, 7, note number width (MIDI key)
- MIN_DIV, 4, smallest legal divider

- sys_clk  in  1  pipeline clock (48 MHz)
- sys_rst  in  1  reset; asynchronous, active-high
- evt_valid  in  1  event present
- evt_ready  out  1  allocator can accept an event
- evt_on  in  1  1 = note-on, 0 = note-off
- evt_note  in  NOTE_W  key number
- evt_div  in  D_W  NCO divider for note-on; ignored for note-off
- panic  in  1  all-notes-off, level-sampled
- voice_div  out  NUM_VOICES*D_W  flattened dividers; voice v at bits [v*D_W +: D_W]
- voice_active  out  NUM_VOICES  voice ownership flags
- alloc_fail  out  1  one-cycle pulse: note-on dropped

## Operation
- Per-voice registers: note[v] (NOTE_W), div[v] (D_W), active[v].
- voice_div[v] = div[v] when active[v] = 1, else 0.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - evt_ready = 1.
  - When evt_valid & evt_ready: latch evt_on, evt_note and evt_div; clear match_hit and free_hit; set idx = 0; go to SCAN.
- SCAN:
  - Examine voice idx once per cycle.
  - If active[idx] and note[idx] == latched note, and match_hit = 0: set match_hit and record match_idx.
  - If !active[idx] and free_hit = 0: set free_hit and record free_idx. This yields the lowest-index free voice.
  - Increment idx. After idx = NUM_VOICES-1 go to COMMIT.
- COMMIT applies exactly one action, then returns to IDLE:
  - Note-on with latched div < MIN_DIV: no state change; alloc_fail pulses.
  - Note-on, match_hit: retrigger. div[match_idx] = latched div. No new voice is used.
  - Note-on, no match, free_hit: note, div and active = 1 are written to free_idx.
  - Note-on, no match, no free voice: dropped; alloc_fail pulses. No voice is stolen.
  - Note-off, match_hit: active[match_idx] = 0 and div[match_idx] = 0.
  - Note-off, no match: ignored, with no flag.
- Invariant: a note number occupies at most one voice. Retrigger guarantees this.
- panic = 1 on any edge:
  - Clears all active and div registers.
  - Aborts any in-flight event without applying it and without pulsing alloc_fail.
  - Forces IDLE.
  - panic has priority over COMMIT in the same cycle.
- Voice registers change only at the COMMIT edge, on panic, or on reset. They never change during SCAN.

## Timing
- Reset values: evt_ready = 1, voice_div = 0, voice_active = 0, alloc_fail = 0, FSM = IDLE, idx = 0.
- Reset asserted mid-event: the event is discarded. After release, the first accept is possible on the first rising edge.
- Accept at edge T0. SCAN occupies edges T1..T(NUM_VOICES). COMMIT occurs at edge T(NUM_VOICES+1).
- voice_div and voice_active update at T(NUM_VOICES+1). alloc_fail is high for exactly the following cycle.
- evt_ready is low from after T0 until after T(NUM_VOICES+1). Maximum throughput is one event per NUM_VOICES+2 cycles; this is 6 cycles for 4 voices.
- Inputs other than panic are sampled only at the accept edge. Changes while evt_ready = 0 are ignored.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset release, then note-on 60/div 200:
  - Voice 0 active with voice_div[0] = 200 exactly 5 edges after accept.
  - evt_ready is low for 5 cycles.
- Note-on keys 60, 62, 64, 65, then key 67:
  - Voices 0–3 hold dividers 200, 180, 160, 150.
  - Key 67 gives alloc_fail = 1 for one cycle and no voice change.
- With the four voices full, note-off 62, then note-on 67/div 120:
  - Voice 1 goes to 0/inactive.
  - Key 67 then lands in voice 1 with 120. Voices 0, 2 and 3 are unchanged.
- Note-on 60/div 200, then note-on 60/div 190:
  - Only voice 0 is active, now at 190.
  - Note-off 70 changes nothing and does not pulse alloc_fail.
- Note-on 60/div 3:
  - alloc_fail pulses and no voice is allocated.
  - Note-on 60/div 4 then allocates voice 0.
- Three voices active, then a note-on accepted with panic asserted 2 cycles later:
  - All voice_div = 0 and voice_active = 0 on the panic edge.
  - evt_ready = 1 on the next cycle.
  - The in-flight note is never allocated.
